// File: rtl/risc23_pkg.sv
// Shared types for the IITB-RISC-23 pipeline control blocks.
package risc23_pkg;

    typedef enum logic {IDLE, SEQ} lmsm_state_t;

    typedef logic [2:0] reg_idx_t;

    localparam int          LMSM_REGS     = 8;
    localparam logic [15:0] DEF_ADDR_STEP = 16'd1;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle between the pipeline datapath (master) and the hazard controller (slave).
interface pipe_hazard_ctrl_if;
    import risc23_pkg::*;

    logic        mem_stall;
    logic        ex_redirect;
    logic        ex_mem_rd;
    logic        ex_rf_we;
    reg_idx_t    ex_waddr;
    logic        rf_valid;
    reg_idx_t    rf_ra;
    reg_idx_t    rf_rb;
    logic        rf_use_ra;
    logic        rf_use_rb;
    logic        rf_is_lmsm;
    logic        rf_is_lm;
    logic [7:0]  rf_lmsm_mask;
    logic [15:0] rf_lmsm_base;

    logic        pc_stall;
    logic        if_id_stall;
    logic        id_rf_stall;
    logic        if_id_flush;
    logic        id_rf_flush;
    logic        rf_ex_stall;
    logic        rf_ex_flush;
    logic        ex_mem_stall;
    logic        uop_valid;
    reg_idx_t    uop_reg;
    logic [15:0] uop_addr;
    logic        uop_is_load;
    logic        uop_last;

    modport master (
        output mem_stall, ex_redirect, ex_mem_rd, ex_rf_we, ex_waddr,
               rf_valid, rf_ra, rf_rb, rf_use_ra, rf_use_rb,
               rf_is_lmsm, rf_is_lm, rf_lmsm_mask, rf_lmsm_base,
        input  pc_stall, if_id_stall, id_rf_stall, if_id_flush, id_rf_flush,
               rf_ex_stall, rf_ex_flush, ex_mem_stall,
               uop_valid, uop_reg, uop_addr, uop_is_load, uop_last
    );

    modport slave (
        input  mem_stall, ex_redirect, ex_mem_rd, ex_rf_we, ex_waddr,
               rf_valid, rf_ra, rf_rb, rf_use_ra, rf_use_rb,
               rf_is_lmsm, rf_is_lm, rf_lmsm_mask, rf_lmsm_base,
        output pc_stall, if_id_stall, id_rf_stall, if_id_flush, id_rf_flush,
               rf_ex_stall, rf_ex_flush, ex_mem_stall,
               uop_valid, uop_reg, uop_addr, uop_is_load, uop_last
    );

endinterface

// File: rtl/lsb_find8.sv
// Lowest-set-bit encoder for an 8-bit register list: index, any-bit flag,
// and the list with that bit removed.
module lsb_find8
    import risc23_pkg::*;
(
    input  logic [7:0] mask,
    output reg_idx_t   index,
    output logic       found,
    output logic [7:0] cleared
);

    logic [7:0] onehot;

    genvar gi;
    generate
        for (gi = 0; gi < LMSM_REGS; gi++) begin : g_bit
            if (gi == 0) begin : g_first
                assign onehot[gi] = mask[gi];
            end else begin : g_rest
                assign onehot[gi] = mask[gi] & ~(|mask[gi-1:0]);
            end
        end
    endgenerate

    // onehot has at most one bit set, so OR-reducing by position class encodes it
    assign index[0] = |(onehot & 8'b1010_1010);
    assign index[1] = |(onehot & 8'b1100_1100);
    assign index[2] = |(onehot & 8'b1111_0000);
    assign found    = |mask;
    assign cleared  = mask & ~onehot;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the six-stage pipeline, plus the LM/SM
// micro-op sequencer that expands a register list into one access per register.
module pipe_hazard_ctrl
    import risc23_pkg::*;
#(
    parameter logic [15:0] ADDR_STEP = DEF_ADDR_STEP
) (
    input  logic              clk,
    input  logic              rst_n,
    pipe_hazard_ctrl_if.slave bus
);

    lmsm_state_t state;
    logic [7:0]  rem_mask;
    logic [15:0] base_q;
    logic [2:0]  cnt;
    logic        is_lm_q;

    logic        in_seq;
    logic [7:0]  active_mask;
    logic [7:0]  cleared_mask;
    reg_idx_t    sel;
    logic        found;
    logic [15:0] base_sel;
    logic [2:0]  cnt_sel;
    logic [15:0] addr_calc;
    logic        start;
    logic        issue;
    logic        last;
    logic        lm_sel;
    logic        src_hit;
    logic        load_use;

    assign in_seq      = (state == SEQ);
    assign active_mask = in_seq ? rem_mask : bus.rf_lmsm_mask;
    assign base_sel    = in_seq ? base_q : bus.rf_lmsm_base;
    assign cnt_sel     = in_seq ? cnt : 3'd0;
    assign addr_calc   = base_sel + 16'(cnt_sel) * ADDR_STEP;
    assign lm_sel      = in_seq ? is_lm_q : bus.rf_is_lm;

    lsb_find8 u_lsb (
        .mask    (active_mask),
        .index   (sel),
        .found   (found),
        .cleared (cleared_mask)
    );

    assign start = ~in_seq & bus.rf_valid & bus.rf_is_lmsm;
    assign issue = in_seq | (start & found);
    assign last  = issue & (cleared_mask == 8'd0);

    // A store micro-op reads the register it is about to store, not the RF operands
    always_comb begin
        if (in_seq && !is_lm_q) begin
            src_hit = (sel == bus.ex_waddr);
        end else begin
            src_hit = (bus.rf_use_ra && (bus.rf_ra == bus.ex_waddr)) ||
                      (bus.rf_use_rb && (bus.rf_rb == bus.ex_waddr));
        end
    end

    assign load_use = bus.ex_mem_rd & bus.ex_rf_we & bus.rf_valid & src_hit;

    logic front_stall;
    logic front_flush;
    logic back_stall;
    logic rf_ex_flush_c;
    logic uop_valid_c;
    logic show_uop;

    always_comb begin
        front_stall   = 1'b0;
        front_flush   = 1'b0;
        back_stall    = 1'b0;
        rf_ex_flush_c = 1'b0;
        uop_valid_c   = 1'b0;
        show_uop      = 1'b0;
        if (rst_n) begin
            if (bus.mem_stall) begin
                front_stall = 1'b1;
                back_stall  = 1'b1;
                uop_valid_c = issue;
                show_uop    = issue;
            end else if (bus.ex_redirect) begin
                front_flush   = 1'b1;
                rf_ex_flush_c = 1'b1;
            end else if (load_use) begin
                front_stall   = 1'b1;
                rf_ex_flush_c = 1'b1;
            end else if (issue) begin
                uop_valid_c = 1'b1;
                show_uop    = 1'b1;
                front_stall = ~last;
            end else if (start) begin
                // empty register list behaves as a NOP bubble
                rf_ex_flush_c = 1'b1;
            end
        end
    end

    assign bus.pc_stall     = front_stall;
    assign bus.if_id_stall  = front_stall;
    assign bus.id_rf_stall  = front_stall;
    assign bus.if_id_flush  = front_flush;
    assign bus.id_rf_flush  = front_flush;
    assign bus.rf_ex_stall  = back_stall;
    assign bus.rf_ex_flush  = rf_ex_flush_c;
    assign bus.ex_mem_stall = back_stall;
    assign bus.uop_valid    = uop_valid_c;
    assign bus.uop_last     = show_uop & last;
    assign bus.uop_reg      = show_uop ? sel : 3'd0;
    assign bus.uop_addr     = show_uop ? addr_calc : 16'd0;
    assign bus.uop_is_load  = show_uop & lm_sel;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            rem_mask <= 8'd0;
            base_q   <= 16'd0;
            cnt      <= 3'd0;
            is_lm_q  <= 1'b0;
        end else if (!bus.mem_stall) begin
            if (bus.ex_redirect) begin
                state    <= IDLE;
                rem_mask <= 8'd0;
                cnt      <= 3'd0;
            end else if (!load_use && issue) begin
                if (in_seq) begin
                    if (last) begin
                        state    <= IDLE;
                        rem_mask <= 8'd0;
                        cnt      <= 3'd0;
                    end else begin
                        rem_mask <= cleared_mask;
                        cnt      <= cnt + 3'd1;
                    end
                end else if (!last) begin
                    state    <= SEQ;
                    rem_mask <= cleared_mask;
                    base_q   <= bus.rf_lmsm_base;
                    cnt      <= 3'd1;
                    is_lm_q  <= bus.rf_is_lm;
                end
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_pipe_hazard_ctrl;
    import risc23_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    pipe_hazard_ctrl_if bus ();

    pipe_hazard_ctrl #(.ADDR_STEP(16'd1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // {pc, if_id, id_rf stall, if_id, id_rf flush, rf_ex stall, rf_ex flush, ex_mem stall}
    logic [7:0]  ctl;
    logic [29:0] obs;
    assign ctl = {bus.pc_stall, bus.if_id_stall, bus.id_rf_stall, bus.if_id_flush,
                  bus.id_rf_flush, bus.rf_ex_stall, bus.rf_ex_flush, bus.ex_mem_stall};
    assign obs = {ctl, bus.uop_valid, bus.uop_last, bus.uop_reg, bus.uop_addr, bus.uop_is_load};

    logic [29:0] want;

    task automatic clear_inputs();
        bus.mem_stall    = 1'b0;
        bus.ex_redirect  = 1'b0;
        bus.ex_mem_rd    = 1'b0;
        bus.ex_rf_we     = 1'b0;
        bus.ex_waddr     = 3'd0;
        bus.rf_valid     = 1'b0;
        bus.rf_ra        = 3'd0;
        bus.rf_rb        = 3'd0;
        bus.rf_use_ra    = 1'b0;
        bus.rf_use_rb    = 1'b0;
        bus.rf_is_lmsm   = 1'b0;
        bus.rf_is_lm     = 1'b0;
        bus.rf_lmsm_mask = 8'd0;
        bus.rf_lmsm_base = 16'd0;
    endtask

    task automatic set_lmsm(input logic lm, input logic [7:0] mask, input logic [15:0] base);
        bus.rf_valid     = 1'b1;
        bus.rf_is_lmsm   = 1'b1;
        bus.rf_is_lm     = lm;
        bus.rf_lmsm_mask = mask;
        bus.rf_lmsm_base = base;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        set_lmsm(1'b1, 8'hFF, 16'h1234);
        bus.mem_stall = 1'b1;
        @(negedge clk);
        checks++;
        if (obs !== 30'd0) begin
            errors++;
            $display("FAIL reset_mem_stall: got %h want %h", obs, 30'd0);
        end
        bus.mem_stall   = 1'b0;
        bus.ex_redirect = 1'b1;
        #1;
        checks++;
        if (obs !== 30'd0) begin
            errors++;
            $display("FAIL reset_redirect: got %h want %h", obs, 30'd0);
        end
        next_cycle();
        rst_n = 1'b1;
        clear_inputs();
        @(negedge clk);
        checks++;
        if (obs !== 30'd0) begin
            errors++;
            $display("FAIL reset_release_idle: got %h want %h", obs, 30'd0);
        end
        next_cycle();
    endtask

    task automatic test_load_use();
        clear_inputs();
        bus.ex_mem_rd = 1'b1;
        bus.ex_rf_we  = 1'b1;
        bus.ex_waddr  = 3'd3;
        bus.rf_valid  = 1'b1;
        bus.rf_ra     = 3'd3;
        bus.rf_use_ra = 1'b1;
        bus.rf_rb     = 3'd5;
        bus.rf_use_rb = 1'b1;
        @(negedge clk);
        want = {8'b1110_0010, 22'd0};
        checks++;
        if (obs !== want) begin
            errors++;
            $display("FAIL load_use_hit: got %h want %h", obs, want);
        end
        next_cycle();
        bus.ex_mem_rd = 1'b0;
        @(negedge clk);
        checks++;
        if (obs !== 30'd0) begin
            errors++;
            $display("FAIL load_use_bubble_gone: got %h want %h", obs, 30'd0);
        end
        next_cycle();
        bus.ex_mem_rd = 1'b1;
        bus.rf_use_ra = 1'b0;
        bus.rf_rb     = 3'd3;
        bus.rf_use_rb = 1'b0;
        @(negedge clk);
        checks++;
        if (obs !== 30'd0) begin
            errors++;
            $display("FAIL load_use_unused_src: got %h want %h", obs, 30'd0);
        end
        next_cycle();
        bus.rf_use_rb = 1'b1;
        @(negedge clk);
        want = {8'b1110_0010, 22'd0};
        checks++;
        if (obs !== want) begin
            errors++;
            $display("FAIL load_use_rb: got %h want %h", obs, want);
        end
        next_cycle();
        bus.ex_rf_we = 1'b0;
        @(negedge clk);
        checks++;
        if (obs !== 30'd0) begin
            errors++;
            $display("FAIL load_use_no_we: got %h want %h", obs, 30'd0);
        end
        next_cycle();
        clear_inputs();
    endtask

    task automatic test_lm_sequence();
        logic [2:0]  regs  [3];
        logic [15:0] addrs [3];
        logic [7:0]  ctls  [3];
        int          stall_cycles;
        regs  = '{3'd2, 3'd5, 3'd7};
        addrs = '{16'h0100, 16'h0101, 16'h0102};
        ctls  = '{8'b1110_0000, 8'b1110_0000, 8'b0000_0000};
        stall_cycles = 0;
        clear_inputs();
        set_lmsm(1'b1, 8'b1010_0100, 16'h0100);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            want = {ctls[i], 1'b1, (i == 2), regs[i], addrs[i], 1'b1};
            if (bus.pc_stall) stall_cycles++;
            checks++;
            if (obs !== want) begin
                errors++;
                $display("FAIL lm_uop[%0d]: got %h want %h", i, obs, want);
            end
            next_cycle();
        end
        clear_inputs();
        @(negedge clk);
        checks++;
        if (obs !== 30'd0) begin
            errors++;
            $display("FAIL lm_after_last: got %h want %h", obs, 30'd0);
        end
        checks++;
        if (stall_cycles != 2) begin
            errors++;
            $display("FAIL lm_front_stall_cycles: got %0d want 2", stall_cycles);
        end
        next_cycle();
    endtask

    task automatic test_redirect();
        clear_inputs();
        set_lmsm(1'b0, 8'b0000_1110, 16'h0020);
        @(negedge clk);
        want = {8'b1110_0000, 1'b1, 1'b0, 3'd1, 16'h0020, 1'b0};
        checks++;
        if (obs !== want) begin
            errors++;
            $display("FAIL sm_first_uop: got %h want %h", obs, want);
        end
        next_cycle();
        bus.ex_redirect = 1'b1;
        @(negedge clk);
        want = {8'b0001_1010, 22'd0};
        checks++;
        if (obs !== want) begin
            errors++;
            $display("FAIL redirect_flush: got %h want %h", obs, want);
        end
        next_cycle();
        clear_inputs();
        @(negedge clk);
        checks++;
        if (obs !== 30'd0) begin
            errors++;
            $display("FAIL redirect_after: got %h want %h", obs, 30'd0);
        end
        next_cycle();
        // a fresh SM must start at its first register, proving the FSM left SEQ
        set_lmsm(1'b0, 8'b0000_1110, 16'h0020);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            want = {(i == 2) ? 8'd0 : 8'b1110_0000, 1'b1, (i == 2), 3'(i + 1),
                    16'h0020 + 16'(i), 1'b0};
            checks++;
            if (obs !== want) begin
                errors++;
                $display("FAIL sm_restart[%0d]: got %h want %h", i, obs, want);
            end
            next_cycle();
        end
        clear_inputs();
    endtask

    task automatic test_mem_stall();
        clear_inputs();
        set_lmsm(1'b1, 8'b0011_1000, 16'h0200);
        @(negedge clk);
        want = {8'b1110_0000, 1'b1, 1'b0, 3'd3, 16'h0200, 1'b1};
        checks++;
        if (obs !== want) begin
            errors++;
            $display("FAIL ms_first_uop: got %h want %h", obs, want);
        end
        next_cycle();
        bus.mem_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (ctl !== 8'b1110_0101 || bus.uop_reg !== 3'd4 || bus.uop_addr !== 16'h0201) begin
                errors++;
                $display("FAIL ms_hold[%0d]: got ctl %b reg %0d addr %h want ctl 11100101 reg 4 addr 0201",
                         i, ctl, bus.uop_reg, bus.uop_addr);
            end
            next_cycle();
        end
        bus.mem_stall = 1'b0;
        @(negedge clk);
        want = {8'b1110_0000, 1'b1, 1'b0, 3'd4, 16'h0201, 1'b1};
        checks++;
        if (obs !== want) begin
            errors++;
            $display("FAIL ms_resume: got %h want %h", obs, want);
        end
        next_cycle();
        @(negedge clk);
        want = {8'b0000_0000, 1'b1, 1'b1, 3'd5, 16'h0202, 1'b1};
        checks++;
        if (obs !== want) begin
            errors++;
            $display("FAIL ms_last: got %h want %h", obs, want);
        end
        next_cycle();
        clear_inputs();
    endtask

    task automatic test_boundaries();
        clear_inputs();
        set_lmsm(1'b1, 8'h00, 16'h0300);
        @(negedge clk);
        want = {8'b0000_0010, 22'd0};
        checks++;
        if (obs !== want) begin
            errors++;
            $display("FAIL mask0_nop: got %h want %h", obs, want);
        end
        next_cycle();
        clear_inputs();
        @(negedge clk);
        checks++;
        if (obs !== 30'd0) begin
            errors++;
            $display("FAIL mask0_after: got %h want %h", obs, 30'd0);
        end
        next_cycle();
        set_lmsm(1'b1, 8'h03, 16'hFFFF);
        @(negedge clk);
        want = {8'b1110_0000, 1'b1, 1'b0, 3'd0, 16'hFFFF, 1'b1};
        checks++;
        if (obs !== want) begin
            errors++;
            $display("FAIL wrap_first: got %h want %h", obs, want);
        end
        next_cycle();
        @(negedge clk);
        want = {8'b0000_0000, 1'b1, 1'b1, 3'd1, 16'h0000, 1'b1};
        checks++;
        if (obs !== want) begin
            errors++;
            $display("FAIL wrap_second: got %h want %h", obs, want);
        end
        next_cycle();
        set_lmsm(1'b0, 8'b0100_0000, 16'h0abc);
        @(negedge clk);
        want = {8'b0000_0000, 1'b1, 1'b1, 3'd6, 16'h0abc, 1'b0};
        checks++;
        if (obs !== want) begin
            errors++;
            $display("FAIL single_reg_sm: got %h want %h", obs, want);
        end
        next_cycle();
        clear_inputs();
    endtask

    task automatic test_reset_mid_seq();
        clear_inputs();
        set_lmsm(1'b1, 8'h0F, 16'h0040);
        next_cycle();
        next_cycle();
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== 30'd0) begin
            errors++;
            $display("FAIL reset_mid_seq: got %h want %h", obs, 30'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        want = {8'b1110_0000, 1'b1, 1'b0, 3'd0, 16'h0040, 1'b1};
        checks++;
        if (obs !== want) begin
            errors++;
            $display("FAIL restart_after_reset: got %h want %h", obs, want);
        end
        clear_inputs();
        next_cycle();
    endtask

    // Reference model: pending registers of an LM/SM in progress are kept as a queue
    bit          m_seq, m_lm;
    logic [15:0] m_base;
    int          m_cnt;
    int          m_q[$];
    bit          n_seq, n_lm;
    logic [15:0] n_base;
    int          n_cnt;
    int          n_q[$];
    logic [29:0] e_obs;

    task automatic model_eval();
        int          lst[$];
        int          cur;
        bit          start, issue, lu, hit, last, lm;
        logic [15:0] addr;
        logic [7:0]  e_ctl;
        n_seq = m_seq; n_lm = m_lm; n_base = m_base; n_cnt = m_cnt; n_q = m_q;
        e_ctl = 8'd0;
        e_obs = 30'd0;
        if (m_seq) lst = m_q;
        else for (int i = 0; i < 8; i++) if (bus.rf_lmsm_mask[i]) lst.push_back(i);
        cur   = (lst.size() > 0) ? lst[0] : 0;
        addr  = (m_seq ? m_base : bus.rf_lmsm_base) + 16'(m_seq ? m_cnt : 0);
        start = !m_seq && bus.rf_valid && bus.rf_is_lmsm;
        issue = m_seq || (start && lst.size() > 0);
        last  = issue && lst.size() == 1;
        lm    = m_seq ? m_lm : bus.rf_is_lm;
        hit   = (m_seq && !m_lm) ? (cur == int'(bus.ex_waddr))
                                 : ((bus.rf_use_ra && bus.rf_ra == bus.ex_waddr) ||
                                    (bus.rf_use_rb && bus.rf_rb == bus.ex_waddr));
        lu    = bus.ex_mem_rd && bus.ex_rf_we && bus.rf_valid && hit;
        if (!rst_n) begin
            n_seq = 1'b0; n_cnt = 0; n_base = 16'd0; n_q.delete();
        end else if (bus.mem_stall) begin
            e_ctl = 8'b1110_0101;
            e_obs = issue ? {e_ctl, 1'b1, last, 3'(cur), addr, lm} : {e_ctl, 22'd0};
        end else if (bus.ex_redirect) begin
            e_obs = {8'b0001_1010, 22'd0};
            n_seq = 1'b0; n_cnt = 0; n_q.delete();
        end else if (lu) begin
            e_obs = {8'b1110_0010, 22'd0};
        end else if (issue) begin
            e_ctl = last ? 8'd0 : 8'b1110_0000;
            e_obs = {e_ctl, 1'b1, last, 3'(cur), addr, lm};
            if (m_seq) begin
                if (last) begin
                    n_seq = 1'b0; n_cnt = 0; n_q.delete();
                end else begin
                    n_q.delete(0); n_cnt = m_cnt + 1;
                end
            end else if (!last) begin
                n_seq = 1'b1; n_q = lst; n_q.delete(0);
                n_base = bus.rf_lmsm_base; n_cnt = 1; n_lm = bus.rf_is_lm;
            end
        end else if (start) begin
            e_obs = {8'b0000_0010, 22'd0};
        end
    endtask

    task automatic test_random();
        clear_inputs();
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        m_seq = 1'b0; m_lm = 1'b0; m_base = 16'd0; m_cnt = 0; m_q.delete();
        next_cycle();
        for (int c = 0; c < 600; c++) begin
            bus.mem_stall    = ($urandom_range(0, 9) == 0);
            bus.ex_redirect  = ($urandom_range(0, 11) == 0);
            bus.ex_mem_rd    = ($urandom_range(0, 3) == 0);
            bus.ex_rf_we     = ($urandom_range(0, 1) == 0);
            bus.ex_waddr     = 3'($urandom_range(0, 7));
            bus.rf_valid     = ($urandom_range(0, 4) != 0);
            bus.rf_ra        = 3'($urandom_range(0, 7));
            bus.rf_rb        = 3'($urandom_range(0, 7));
            bus.rf_use_ra    = 1'($urandom_range(0, 1));
            bus.rf_use_rb    = 1'($urandom_range(0, 1));
            bus.rf_is_lmsm   = ($urandom_range(0, 2) == 0);
            bus.rf_is_lm     = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0:       bus.rf_lmsm_mask = 8'd0;
                1:       bus.rf_lmsm_mask = 8'd1 << $urandom_range(0, 7);
                default: bus.rf_lmsm_mask = 8'($urandom);
            endcase
            bus.rf_lmsm_base = ($urandom_range(0, 4) == 0) ? 16'hFFFD : 16'($urandom);
            @(negedge clk);
            model_eval();
            checks++;
            if (obs !== e_obs) begin
                errors++;
                $display("FAIL random[%0d]: got %h want %h", c, obs, e_obs);
            end
            @(posedge clk);
            m_seq = n_seq; m_lm = n_lm; m_base = n_base; m_cnt = n_cnt; m_q = n_q;
            #1;
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_lm_sequence();
        test_redirect();
        test_mem_stall();
        test_boundaries();
        test_reset_mid_seq();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
